// File: rtl/fir_out_sink.sv
// Capture buffer after the FIR: a contiguous din_st burst is stored, then served to a reader (optional peak via SINK_PEAK_EN).
// Latency: a sample is in memory on the edge it is accepted; rd_data/rd_valid follow an accepted rd_en by one cycle.
// Backpressure: none; din_st while holding is dropped and flagged in sticky ovf, rd_en outside HOLD is ignored.
module fir_out_sink #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          din_st,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic [AW:0]   count,
  output logic          ovf
`ifdef SINK_PEAK_EN
  ,
  output logic [DW-1:0] peak
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic          wr_en;
  logic          rd_acc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_inc;
  logic [AW:0]   rd_ptr_inc;
  logic [DW-1:0] mem [DEPTH];

  assign count_inc  = count + 1'b1;
  assign rd_ptr_inc = {1'b0, rd_ptr} + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // IDLE and CAP write identically: count and wr_ptr are both 0 on entry to IDLE.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_acc    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, CAP: begin
          if (din_st) begin
            wr_en     = 1'b1;
            state_nxt = (count_inc == FULL) ? HOLD : CAP;
          end else if (state == CAP) begin
            state_nxt = HOLD;
          end
        end
        HOLD: rd_acc = rd_en;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (clr) begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      done     <= (state_nxt == HOLD);
      rd_valid <= rd_acc;
      if (wr_en) begin
        count  <= count_inc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (state == HOLD && din_st) ovf <= 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= (rd_ptr_inc == count) ? '0 : rd_ptr_inc[AW-1:0];
      end
    end
  end

`ifdef SINK_PEAK_EN
  localparam logic [DW:0]   MAX_W = (DW+1)'((2 ** (DW-1)) - 1);
  localparam logic [DW-1:0] MAX_P = MAX_W[DW-1:0];

  logic [DW:0]   din_ext;
  logic [DW:0]   abs_w;
  logic [DW-1:0] din_abs;

  // |-2^(DW-1)| does not fit in DW signed bits, so it clamps to the positive max.
  assign din_ext = {din[DW-1], din};
  assign abs_w   = din[DW-1] ? (~din_ext + 1'b1) : din_ext;
  assign din_abs = (abs_w > MAX_W) ? MAX_P : abs_w[DW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          peak <= '0;
    else if (clr)                      peak <= '0;
    else if (wr_en && din_abs > peak)  peak <= din_abs;
  end
`endif

endmodule

// File: tb/tb_fir_out_sink.sv
// Directed bench for fir_out_sink: capture, wrap-around reads, gap-ended capture, overflow, clr and reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fir_out_sink;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          din_st;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic [AW:0]   count;
  logic          ovf;
`ifdef SINK_PEAK_EN
  logic [DW-1:0] peak;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fir_out_sink #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .din_st   (din_st),
    .din      (din),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .count    (count),
    .ovf      (ovf)
`ifdef SINK_PEAK_EN
    ,
    .peak     (peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp3 [6];
    exp3[0] = 16'hFFFD; exp3[1] = 16'hFFFE; exp3[2] = 16'hFFFF;
    exp3[3] = 16'h0000; exp3[4] = 16'h0001; exp3[5] = 16'h0002;

    rst = 1'b0; clr = 1'b0; din_st = 1'b0; din = '0; rd_en = 1'b0;
    step(); step();
    check("rst_done", {31'b0, done}, 0);
    check("rst_count", {27'b0, count}, 0);
    check("rst_rd_valid", {31'b0, rd_valid}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    check("rst_rd_data", {16'b0, rd_data}, 0);
    @(negedge clk) rst = 1'b1;
    step();

    // Reset in the middle of a capture
    din_st = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = DW'(100 + i);
      step();
    end
    check("t1_count_pre", {27'b0, count}, 5);
    rst = 1'b0;
    din_st = 1'b0;
    #2;
    check("t1_count_async", {27'b0, count}, 0);
    check("t1_done_async", {31'b0, done}, 0);
    @(negedge clk) rst = 1'b1;
    step();
    check("t1_idle_count", {27'b0, count}, 0);

    // Full 16-sample capture, then 17 back-to-back reads with wrap
    din_st = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      din = DW'(i);
      step();
      if (i == DEPTH - 1) check("t2_done_before_last", {31'b0, done}, 0);
    end
    din_st = 1'b0;
    check("t2_done", {31'b0, done}, 1);
    check("t2_count", {27'b0, count}, DEPTH);
    rd_en = 1'b1;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      step();
      check("t2_rd_valid", {31'b0, rd_valid}, 1);
      check("t2_rd_data", {16'b0, rd_data}, (i > DEPTH) ? 1 : i);
    end
    rd_en = 1'b0;
    step();
    check("t2_rd_valid_idle", {31'b0, rd_valid}, 0);

    // Six signed samples, capture ended by a gap
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t3_clr_count", {27'b0, count}, 0);
    check("t3_clr_done", {31'b0, done}, 0);
    din_st = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = exp3[i];
      step();
    end
    check("t3_done_before_gap", {31'b0, done}, 0);
    din_st = 1'b0;
    step();
    check("t3_count", {27'b0, count}, 6);
    check("t3_done", {31'b0, done}, 1);
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("t3_rd_valid", {31'b0, rd_valid}, 1);
      check("t3_rd_data", {16'b0, rd_data}, {16'b0, exp3[i % 6]});
      step();
      check("t3_rd_valid_drop", {31'b0, rd_valid}, 0);
    end

    // Overflow while holding; next read (rd_ptr=1) unaffected
    din_st = 1'b1;
    din = 16'h7FFF;
    step();
    din_st = 1'b0;
    check("t4_ovf", {31'b0, ovf}, 1);
    check("t4_count", {27'b0, count}, 6);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t4_rd_data", {16'b0, rd_data}, 32'h0000FFFE);
    step();
    check("t4_ovf_sticky", {31'b0, ovf}, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr_ovf", {31'b0, ovf}, 0);
    check("t4_clr_done", {31'b0, done}, 0);
    check("t4_clr_count", {27'b0, count}, 0);

    // rd_en outside HOLD, clr colliding with din_st, single-sample capture
    rd_en = 1'b1;
    step();
    check("t5_rd_valid_idle", {31'b0, rd_valid}, 0);
    din_st = 1'b1;
    din = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_rd_valid_cap", {31'b0, rd_valid}, 0);
    end
    rd_en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    din_st = 1'b0;
    check("t5_clr_din_count", {27'b0, count}, 0);
    step();
    check("t5_idle_hold_count", {27'b0, count}, 0);
    check("t5_idle_done", {31'b0, done}, 0);
    din_st = 1'b1;
    din = 16'd42;
    step();
    din_st = 1'b0;
    step();
    check("t5_one_count", {27'b0, count}, 1);
    check("t5_one_done", {31'b0, done}, 1);
    rd_en = 1'b1;
    step();
    check("t5_one_rd0", {16'b0, rd_data}, 42);
    step();
    check("t5_one_rd1", {16'b0, rd_data}, 42);
    check("t5_one_valid", {31'b0, rd_valid}, 1);
    rd_en = 1'b0;

`ifdef SINK_PEAK_EN
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_peak_clr", {16'b0, peak}, 0);
    din_st = 1'b1;
    din = 16'd100;
    step();
    check("t6_peak_100", {16'b0, peak}, 100);
    din = 16'hFED4;
    step();
    check("t6_peak_300", {16'b0, peak}, 300);
    din = 16'h8000;
    step();
    check("t6_peak_sat", {16'b0, peak}, 32'h7FFF);
    din = 16'd7;
    step();
    check("t6_peak_keep", {16'b0, peak}, 32'h7FFF);
    din_st = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
